calc_rs: RTL and testbench
==========================

// Module: calc_rs
// PURPOSE
//  Reservation station for the integer-calc class: LUI, AUIPC, R-type ALU ops and I-type ALU ops.
//  Buffers dispatched calc instructions until both operands are valid.
//  Snoops the two CDBs for operand tags and issues at most one ready entry per cycle to the single ALU.
//  Sits between decoder/dispatch and the ALU; the ALU result returns on CDB0 tagged with the ROB index.
// PARAMETERS
//  RS_SIZE   8    number of entries; power of two, >=2
//  ROB_W     4    ROB tag width
//  XLEN      32   operand width
// PORTS
//  clk_in          in   1      clock; single clock domain
//  rst_in          in   1      synchronous, active-low reset
//  rdy_in          in   1      global ready; low = freeze
//  clear_in        in   1      flush on mispredict
//  iss_valid_in    in   1      dispatch request
//  iss_op_in       in   6      opcode (`LUI..`SRAI encoding)
//  iss_vj_in       in   XLEN   operand j; PC for AUIPC, 0 for LUI
//  iss_qj_in       in   ROB_W  tag j
//  iss_qj_wait_in  in   1      operand j pending
//  iss_vk_in       in   XLEN   operand k or immediate
//  iss_qk_in       in   ROB_W  tag k
//  iss_qk_wait_in  in   1      operand k pending
//  iss_dest_in     in   ROB_W  ROB tag of result
//  full_out        out  1      no free entry
//  cdb0_valid_in   in   1      ALU result broadcast
//  cdb0_tag_in     in   ROB_W  ALU result tag
//  cdb0_val_in     in   XLEN   ALU result value
//  cdb1_valid_in   in   1      load/store-buffer broadcast
//  cdb1_tag_in     in   ROB_W  LSB result tag
//  cdb1_val_in     in   XLEN   LSB result value
//  alu_valid_out   out  1      ALU request
//  alu_op_out      out  6      ALU opcode
//  alu_a_out       out  XLEN   ALU operand a
//  alu_b_out       out  XLEN   ALU operand b
//  alu_dest_out    out  ROB_W  ALU destination tag
// BEHAVIOUR
//  Reset: rst_in==0 at posedge clears all entry busy bits, alu_valid_out, alu_op/a/b/dest_out, full_out.
//  Priority per cycle: reset > clear_in > rdy_in==0 > normal.
//  clear_in=1: all entries invalid next cycle; alu_valid_out=0; same-cycle dispatch dropped.
//  rdy_in=0: no state change; alu_valid_out registered 0 so nothing is re-issued.
//  Entry state: busy, op, vj, qj, wj, vk, qk, wk, dest. Ready = busy & !wj & !wk.
//  Dispatch
//   - Accepted when iss_valid_in & !full_out & op is calc-class.
//   - Written into the lowest-index free entry.
//   - A non-calc op is dropped; the bench asserts it never occurs.
//   - Same-cycle CDB match on a pending operand is captured at dispatch: the entry stores the value, w=0.
//  Wake-up
//   - Each cycle, every busy entry with w=1 and tag==cdbX_tag & cdbX_valid captures the value, clears w.
//   - CDB0 and CDB1 may both match different operands of one entry in the same cycle; both are captured.
//  Select
//   - Lowest-index ready entry at cycle start is issued.
//   - alu_*_out registered: valid 1 cycle later, for exactly 1 cycle.
//   - The entry is freed the same edge. An entry woken this cycle is issuable next cycle, not this one.
//   - No ready entry: alu_valid_out=0. Operand outputs hold last values (don't-care).
//  full_out: combinational; 1 iff all RS_SIZE entries busy at cycle start.
//   - An issue in the same cycle does not lower full_out until the next cycle.
//  Throughput: one dispatch and one issue per cycle, sustained.
//  Latency: dispatch-with-ready-operands to alu_valid_out = 2 edges.
// STRUCTURE
//  Shared `define header: opcode encodings (`LUI..`SRAI), RS_SIZE, ROB_W.
//  The calc-class decode is the existing calc-class predicate, instantiated on iss_op_in.
//  Sub-module calc_rs_pick: parameterised lowest-index priority encoder.
//  Two instances: free-slot pick and ready-slot pick. Each outputs index + found flag.
// TESTING
//  1. Reset: hold rst_in=0 2 cycles -> alu_valid_out=0, full_out=0; no issue follows.
//  2. Ready dispatch: ADDI vj=5, vk=7, dest=3 -> next cycle alu_valid_out=1, a=5, b=7, dest=3, op=`ADDI.
//  3. Wake-up
//     - Dispatch ADD waiting on qj=2, vk=1; 2 cycles later cdb1 tag=2 val=0x10 -> issue next cycle, a=0x10.
//     - Same-cycle CDB at dispatch also issues.
//  4. Full: 8 dispatches with qj=9 pending -> full_out=1, 9th ignored.
//     - cdb0 tag 9 -> entries 0..7 issue in index order over 8 consecutive cycles.
//     - full_out drops after the first issue.
//  5. Flush/pause
//     - clear_in with 3 busy entries -> no alu_valid_out afterwards, full_out=0.
//     - rdy_in=0 for 3 cycles with a ready entry -> no issue until rdy_in=1, then exactly one issue.

Source files
------------

// File: rtl/calc_rs_pkg.sv
// Shared definitions for the calc-class reservation station: opcodes, widths, entry layout.
package calc_rs_pkg;

  localparam int unsigned RS_SIZE_DEF = 8;
  localparam int unsigned ROB_W       = 4;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned OP_W        = 6;

  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd3;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd4;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd5;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd6;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd7;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd8;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd9;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd10;
  localparam logic [OP_W-1:0] OP_OR    = 6'd11;
  localparam logic [OP_W-1:0] OP_AND   = 6'd12;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd13;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd14;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd15;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd16;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd17;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd18;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd19;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd20;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd21;

  typedef struct packed {
    logic [XLEN-1:0]  val;
    logic [ROB_W-1:0] tag;
    logic             pend;
  } operand_t;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } cdb_t;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    operand_t         j;
    operand_t         k;
    logic [ROB_W-1:0] dest;
  } rs_entry_t;

  // Calc class is the contiguous LUI..SRAI opcode range.
  function automatic logic is_calc(input logic [OP_W-1:0] op);
    return (op >= OP_LUI) && (op <= OP_SRAI);
  endfunction

  // A pending operand captures the value from whichever CDB carries its tag.
  function automatic operand_t snoop(input operand_t o, input cdb_t c0, input cdb_t c1);
    operand_t r;
    r = o;
    if (o.pend && c0.valid && (o.tag == c0.tag)) begin
      r.val  = c0.val;
      r.pend = 1'b0;
    end else if (o.pend && c1.valid && (o.tag == c1.tag)) begin
      r.val  = c1.val;
      r.pend = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/calc_rs_pick.sv
// Lowest-index priority encoder returning the winning index and a found flag.
module calc_rs_pick #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c
);

  always_comb begin
    idx_c   = '0;
    found_c = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_c   = IDX_W'(i);
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_rs.sv
// Reservation station for calc-class ops: buffers dispatches, snoops both CDBs,
// and issues the lowest-index ready entry to the ALU each cycle.
module calc_rs
  import calc_rs_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             iss_valid_in,
  input  logic [OP_W-1:0]  iss_op_in,
  input  logic [XLEN-1:0]  iss_vj_in,
  input  logic [ROB_W-1:0] iss_qj_in,
  input  logic             iss_qj_wait_in,
  input  logic [XLEN-1:0]  iss_vk_in,
  input  logic [ROB_W-1:0] iss_qk_in,
  input  logic             iss_qk_wait_in,
  input  logic [ROB_W-1:0] iss_dest_in,
  output logic             full_out,
  input  logic             cdb0_valid_in,
  input  logic [ROB_W-1:0] cdb0_tag_in,
  input  logic [XLEN-1:0]  cdb0_val_in,
  input  logic             cdb1_valid_in,
  input  logic [ROB_W-1:0] cdb1_tag_in,
  input  logic [XLEN-1:0]  cdb1_val_in,
  output logic             alu_valid_out,
  output logic [OP_W-1:0]  alu_op_out,
  output logic [XLEN-1:0]  alu_a_out,
  output logic [XLEN-1:0]  alu_b_out,
  output logic [ROB_W-1:0] alu_dest_out
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);

  rs_entry_t          ent_q [RS_SIZE];
  rs_entry_t          ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   rdy_idx;
  logic               free_found;
  logic               rdy_found;
  logic               dispatch;
  cdb_t               c0;
  cdb_t               c1;
  operand_t           new_j;
  operand_t           new_k;

  always_comb begin
    c0 = '{valid: cdb0_valid_in, tag: cdb0_tag_in, val: cdb0_val_in};
    c1 = '{valid: cdb1_valid_in, tag: cdb1_tag_in, val: cdb1_val_in};
    new_j = snoop('{val: iss_vj_in, tag: iss_qj_in, pend: iss_qj_wait_in}, c0, c1);
    new_k = snoop('{val: iss_vk_in, tag: iss_qk_in, pend: iss_qk_wait_in}, c0, c1);
  end

  // Readiness is judged on registered state, so a same-cycle wake-up issues next cycle.
  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      free_vec[i]  = !ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && !ent_q[i].j.pend && !ent_q[i].k.pend;
    end
  end

  calc_rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_pick (
    .req     (free_vec),
    .idx_c   (free_idx),
    .found_c (free_found)
  );

  calc_rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_pick (
    .req     (ready_vec),
    .idx_c   (rdy_idx),
    .found_c (rdy_found)
  );

  assign full_out = !free_found;
  assign dispatch = iss_valid_in && !full_out && is_calc(iss_op_in);

  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        ent_d[i].j = snoop(ent_q[i].j, c0, c1);
        ent_d[i].k = snoop(ent_q[i].k, c0, c1);
      end
    end
    if (rdy_found) begin
      ent_d[rdy_idx].busy = 1'b0;
    end
    if (dispatch) begin
      ent_d[free_idx] = '{busy: 1'b1, op: iss_op_in, j: new_j, k: new_k, dest: iss_dest_in};
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent_q[i] <= '0;
      end
      alu_valid_out <= 1'b0;
      alu_op_out    <= '0;
      alu_a_out     <= '0;
      alu_b_out     <= '0;
      alu_dest_out  <= '0;
    end else if (clear_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent_q[i].busy <= 1'b0;
      end
      alu_valid_out <= 1'b0;
    end else if (!rdy_in) begin
      alu_valid_out <= 1'b0;
    end else begin
      ent_q         <= ent_d;
      alu_valid_out <= rdy_found;
      if (rdy_found) begin
        alu_op_out   <= ent_q[rdy_idx].op;
        alu_a_out    <= ent_q[rdy_idx].j.val;
        alu_b_out    <= ent_q[rdy_idx].k.val;
        alu_dest_out <= ent_q[rdy_idx].dest;
      end
    end
  end

endmodule

// File: tb/tb_calc_rs.sv
// Directed bench for calc_rs: table of single-entry dispatch/issue vectors plus
// hand-written wake-up, full, flush and pause sequences.
module tb_calc_rs;
  import calc_rs_pkg::*;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, clear_in;
  logic             iss_valid_in;
  logic [5:0]       iss_op_in;
  logic [31:0]      iss_vj_in, iss_vk_in;
  logic [3:0]       iss_qj_in, iss_qk_in, iss_dest_in;
  logic             iss_qj_wait_in, iss_qk_wait_in;
  logic             full_out;
  logic             cdb0_valid_in, cdb1_valid_in;
  logic [3:0]       cdb0_tag_in, cdb1_tag_in;
  logic [31:0]      cdb0_val_in, cdb1_val_in;
  logic             alu_valid_out;
  logic [5:0]       alu_op_out;
  logic [31:0]      alu_a_out, alu_b_out;
  logic [3:0]       alu_dest_out;

  int errors = 0;
  int checks = 0;

  calc_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .iss_valid_in(iss_valid_in), .iss_op_in(iss_op_in),
    .iss_vj_in(iss_vj_in), .iss_qj_in(iss_qj_in), .iss_qj_wait_in(iss_qj_wait_in),
    .iss_vk_in(iss_vk_in), .iss_qk_in(iss_qk_in), .iss_qk_wait_in(iss_qk_wait_in),
    .iss_dest_in(iss_dest_in), .full_out(full_out),
    .cdb0_valid_in(cdb0_valid_in), .cdb0_tag_in(cdb0_tag_in), .cdb0_val_in(cdb0_val_in),
    .cdb1_valid_in(cdb1_valid_in), .cdb1_tag_in(cdb1_tag_in), .cdb1_val_in(cdb1_val_in),
    .alu_valid_out(alu_valid_out), .alu_op_out(alu_op_out),
    .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_dest_out(alu_dest_out)
  );

  always #5 clk_in = ~clk_in;

  // Only calc-class ops may ever be dispatched by this bench.
  always @(posedge clk_in) begin
    if (iss_valid_in) begin
      assert (is_calc(iss_op_in)) else $error("non-calc op dispatched: %0d", iss_op_in);
    end
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj;
    logic [3:0]  qj;
    logic        wj;
    logic [31:0] vk;
    logic [3:0]  qk;
    logic        wk;
    logic [3:0]  dest;
    logic        c0v;
    logic [3:0]  c0t;
    logic [31:0] c0val;
    logic        c1v;
    logic [3:0]  c1t;
    logic [31:0] c1val;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid_in = 1'b0; iss_op_in = OP_ADD;
    iss_vj_in = '0; iss_qj_in = '0; iss_qj_wait_in = 1'b0;
    iss_vk_in = '0; iss_qk_in = '0; iss_qk_wait_in = 1'b0; iss_dest_in = '0;
    cdb0_valid_in = 1'b0; cdb0_tag_in = '0; cdb0_val_in = '0;
    cdb1_valid_in = 1'b0; cdb1_tag_in = '0; cdb1_val_in = '0;
  endtask

  task automatic drive_iss(input logic [5:0] op, input logic [31:0] vj, input logic [3:0] qj,
                           input logic wj, input logic [31:0] vk, input logic [3:0] qk,
                           input logic wk, input logic [3:0] dest);
    iss_valid_in = 1'b1; iss_op_in = op;
    iss_vj_in = vj; iss_qj_in = qj; iss_qj_wait_in = wj;
    iss_vk_in = vk; iss_qk_in = qk; iss_qk_wait_in = wk; iss_dest_in = dest;
  endtask

  initial begin
    vecs[0] = '{OP_ADDI, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0, 4'd3,
                1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd5, 32'd7};
    vecs[1] = '{OP_LUI, 32'd0, 4'd0, 1'b0, 32'h1234_5000, 4'd0, 1'b0, 4'd1,
                1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'h1234_5000};
    vecs[2] = '{OP_ADD, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0, 1'b0, 4'd4,
                1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h10, 32'h10, 32'd1};
    vecs[3] = '{OP_SUB, 32'd9, 4'd0, 1'b0, 32'd0, 4'd6, 1'b1, 4'd8,
                1'b1, 4'd6, 32'hdead_beef, 1'b0, 4'd0, 32'd0, 32'd9, 32'hdead_beef};
    vecs[4] = '{OP_AND, 32'd0, 4'd3, 1'b1, 32'd0, 4'd5, 1'b1, 4'd11,
                1'b1, 4'd3, 32'ha, 1'b1, 4'd5, 32'hb, 32'ha, 32'hb};
    vecs[5] = '{OP_SRAI, 32'h8000_0000, 4'd0, 1'b0, 32'd4, 4'd0, 1'b0, 4'd15,
                1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'h8000_0000, 32'd4};

    idle_inputs();
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    step(); step();
    chk("reset alu_valid", 32'(alu_valid_out), 32'd0);
    chk("reset full", 32'(full_out), 32'd0);
    chk("reset alu_dest", 32'(alu_dest_out), 32'd0);
    rst_in = 1'b1;
    step();
    chk("post-reset no issue", 32'(alu_valid_out), 32'd0);

    // Single-entry vectors: dispatch edge, then issue edge, then idle.
    for (int v = 0; v < 6; v++) begin
      drive_iss(vecs[v].op, vecs[v].vj, vecs[v].qj, vecs[v].wj,
                vecs[v].vk, vecs[v].qk, vecs[v].wk, vecs[v].dest);
      cdb0_valid_in = vecs[v].c0v; cdb0_tag_in = vecs[v].c0t; cdb0_val_in = vecs[v].c0val;
      cdb1_valid_in = vecs[v].c1v; cdb1_tag_in = vecs[v].c1t; cdb1_val_in = vecs[v].c1val;
      step();
      idle_inputs();
      chk($sformatf("vec%0d not yet", v), 32'(alu_valid_out), 32'd0);
      step();
      chk($sformatf("vec%0d valid", v), 32'(alu_valid_out), 32'd1);
      chk($sformatf("vec%0d op", v), 32'(alu_op_out), 32'(vecs[v].op));
      chk($sformatf("vec%0d a", v), alu_a_out, vecs[v].ea);
      chk($sformatf("vec%0d b", v), alu_b_out, vecs[v].eb);
      chk($sformatf("vec%0d dest", v), 32'(alu_dest_out), 32'(vecs[v].dest));
      step();
      chk($sformatf("vec%0d one-shot", v), 32'(alu_valid_out), 32'd0);
    end

    // Wake-up through CDB1 after a wrong-tag broadcast on CDB0.
    drive_iss(OP_ADD, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0, 1'b0, 4'd5);
    step();
    idle_inputs();
    cdb0_valid_in = 1'b1; cdb0_tag_in = 4'd3; cdb0_val_in = 32'h77;
    step();
    idle_inputs();
    chk("wake wrong tag", 32'(alu_valid_out), 32'd0);
    cdb1_valid_in = 1'b1; cdb1_tag_in = 4'd2; cdb1_val_in = 32'h10;
    step();
    idle_inputs();
    chk("wake same edge no issue", 32'(alu_valid_out), 32'd0);
    step();
    chk("wake issue valid", 32'(alu_valid_out), 32'd1);
    chk("wake issue a", alu_a_out, 32'h10);
    chk("wake issue b", alu_b_out, 32'd1);
    chk("wake issue dest", 32'(alu_dest_out), 32'd5);
    step();

    // Fill all entries waiting on tag 9; a 9th dispatch must be dropped.
    for (int i = 0; i < 8; i++) begin
      drive_iss(OP_ADD, 32'd0, 4'd9, 1'b1, 32'(i), 4'd0, 1'b0, 4'(i));
      step();
    end
    chk("full after 8", 32'(full_out), 32'd1);
    drive_iss(OP_ADDI, 32'd1, 4'd0, 1'b0, 32'd99, 4'd0, 1'b0, 4'd14);
    step();
    idle_inputs();
    chk("full after 9th", 32'(full_out), 32'd1);
    chk("full no issue", 32'(alu_valid_out), 32'd0);
    cdb0_valid_in = 1'b1; cdb0_tag_in = 4'd9; cdb0_val_in = 32'h100;
    step();
    idle_inputs();
    chk("full wake no issue", 32'(alu_valid_out), 32'd0);
    chk("full still set", 32'(full_out), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("drain%0d valid", i), 32'(alu_valid_out), 32'd1);
      chk($sformatf("drain%0d dest", i), 32'(alu_dest_out), 32'(i));
      chk($sformatf("drain%0d a", i), alu_a_out, 32'h100);
      chk($sformatf("drain%0d b", i), alu_b_out, 32'(i));
      if (i == 0) chk("full drops", 32'(full_out), 32'd0);
    end
    step();
    chk("9th dropped", 32'(alu_valid_out), 32'd0);

    // Flush with 3 busy entries and a same-cycle ready dispatch.
    for (int i = 0; i < 3; i++) begin
      drive_iss(OP_OR, 32'd0, 4'd7, 1'b1, 32'd2, 4'd0, 1'b0, 4'(i + 1));
      step();
    end
    drive_iss(OP_ADDI, 32'd3, 4'd0, 1'b0, 32'd4, 4'd0, 1'b0, 4'd12);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    idle_inputs();
    chk("clear alu_valid", 32'(alu_valid_out), 32'd0);
    chk("clear full", 32'(full_out), 32'd0);
    cdb0_valid_in = 1'b1; cdb0_tag_in = 4'd7; cdb0_val_in = 32'h5;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("clear quiet%0d", i), 32'(alu_valid_out), 32'd0);
    end

    // Pause with a ready entry: no issue until rdy_in returns, then exactly one.
    drive_iss(OP_ADDI, 32'd1, 4'd0, 1'b0, 32'd2, 4'd0, 1'b0, 4'd6);
    step();
    idle_inputs();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("pause%0d", i), 32'(alu_valid_out), 32'd0);
    end
    rdy_in = 1'b1;
    step();
    chk("resume valid", 32'(alu_valid_out), 32'd1);
    chk("resume dest", 32'(alu_dest_out), 32'd6);
    chk("resume a", alu_a_out, 32'd1);
    chk("resume b", alu_b_out, 32'd2);
    step();
    chk("resume one-shot", 32'(alu_valid_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
